// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// opcode constants, instruction word layout and parameter defaults.
package fetch_sequencer_pkg;

    localparam int ADDR_W_DEF  = 5;
    localparam int TIMEOUT_DEF = 15;

    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_ROM,
        S_ISSUE,
        S_IMM,
        S_EXEC,
        S_HALT,
        S_ERR
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] x;
        logic [2:0] y;
    } instr_t;

endpackage

// File: rtl/fetch_sequencer_timeout.sv
// seq_timeout: loadable down-counter guarding the Run -> Done window.
// Loaded with TIMEOUT on the ISSUE cycle, it counts down once per waiting
// cycle. Expired is raised on the last cycle in which Done is still accepted,
// so a missing Done on that cycle sends the sequencer to ERR.
module seq_timeout
    import fetch_sequencer_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic Clock,
    input  logic Clear,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Reload on issue, otherwise count down while waiting for Done.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(TIMEOUT);
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt <= CW'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: walks an instruction ROM, hands each word (plus the
// immediate of an mvi) to the processor with a one-cycle Run pulse, waits
// for Done with a timeout, and tracks PC and a saturating retire count.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Step,
    output logic [ADDR_W-1:0] RomAddr,
    input  logic [8:0]        RomQ,
    output logic [8:0]        ProcDin,
    output logic              ProcRun,
    input  logic              ProcDone,
    output logic [ADDR_W-1:0] PC,
    output logic [7:0]        InstrCount,
    output logic              Busy,
    output logic              Halted,
    output logic              Error
);

    state_t            state, state_n;
    instr_t            ir;
    instr_t            rom_w;
    logic [8:0]        imm;
    logic              sel_imm;
    logic              is_mvi;
    logic              rom_mvi;
    logic              rom_halt;
    logic              retire;
    logic              restart;
    logic              tmo_load;
    logic              tmo_en;
    logic              tmo_expired;
    logic [ADDR_W-1:0] pc_inc;

    assign rom_w    = instr_t'(RomQ);
    assign rom_mvi  = (rom_w.op == OP_MVI);
    assign rom_halt = (rom_w.op == OP_HALT);
    assign is_mvi   = (ir.op == OP_MVI);
    assign pc_inc   = is_mvi ? ADDR_W'(2) : ADDR_W'(1);

    seq_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
        .Clock   (Clock),
        .Clear   (Clear),
        .load    (tmo_load),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // State register.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state logic, retire/restart strobes and timeout control.
    always_comb begin
        state_n  = state;
        retire   = 1'b0;
        restart  = 1'b0;
        tmo_load = 1'b0;
        tmo_en   = 1'b0;
        case (state)
            S_IDLE:     if (Start && !Stop) state_n = S_FETCH;
            S_FETCH:    state_n = S_WAIT_ROM;
            S_WAIT_ROM: state_n = rom_halt ? S_HALT : S_ISSUE;
            S_ISSUE: begin
                tmo_load = 1'b1;
                state_n  = is_mvi ? S_IMM : S_EXEC;
            end
            S_IMM, S_EXEC: begin
                if (ProcDone) begin
                    retire  = 1'b1;
                    state_n = (Step || Stop) ? S_IDLE : S_FETCH;
                end else if (tmo_expired) begin
                    state_n = S_ERR;
                end else begin
                    tmo_en  = 1'b1;
                    state_n = S_EXEC;
                end
            end
            S_HALT, S_ERR: begin
                if (Start) begin
                    restart = 1'b1;
                    state_n = S_FETCH;
                end
            end
            default:    state_n = S_IDLE;
        endcase
    end

    // Datapath: instruction/immediate capture, Run pulse, PC and retire count.
    // A HALT word is never issued, so IR keeps the last word sent to the
    // processor and DIN holds steady outside ISSUE/IMM.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            ir         <= '0;
            imm        <= '0;
            sel_imm    <= 1'b0;
            ProcRun    <= 1'b0;
            PC         <= '0;
            InstrCount <= '0;
        end else begin
            ProcRun <= (state_n == S_ISSUE);
            if (state == S_WAIT_ROM && !rom_halt) begin
                ir      <= rom_w;
                sel_imm <= 1'b0;
            end
            if (state == S_ISSUE && is_mvi) begin
                imm     <= RomQ;
                sel_imm <= 1'b1;
            end
            if (retire) begin
                PC <= PC + pc_inc;
                if (InstrCount != 8'hFF) InstrCount <= InstrCount + 8'd1;
            end else if (restart) begin
                PC         <= '0;
                InstrCount <= '0;
            end
        end
    end

    // The immediate lives at PC+1; ask for it while the opcode is decoded so
    // it arrives from the registered ROM during ISSUE.
    assign RomAddr = (state == S_WAIT_ROM && rom_mvi) ? PC + 1'b1 : PC;
    assign ProcDin = sel_imm ? imm : ir;
    assign Busy    = !(state inside {S_IDLE, S_HALT, S_ERR});
    assign Halted  = (state == S_HALT);
    assign Error   = (state == S_ERR);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: registered ROM model, processor
// model with programmable Done delay, table-driven programs, hand-written
// corner sequences and a randomized single-step run against a program model.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int AW  = 5;
    localparam int TMO = 15;
    localparam logic [8:0] W_HALT = 9'h1C0;
    localparam logic [8:0] W_MV   = 9'h001;
    localparam logic [8:0] W_ADD  = 9'h081;
    localparam logic [8:0] W_MVI  = 9'h040;

    logic          Clock = 1'b0;
    logic          Clear, Start, Stop, Step;
    logic [AW-1:0] RomAddr, PC;
    logic [8:0]    RomQ, ProcDin;
    logic          ProcRun, ProcDone, Busy, Halted, Error;
    logic [7:0]    InstrCount;

    fetch_sequencer #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .Stop(Stop), .Step(Step),
        .RomAddr(RomAddr), .RomQ(RomQ), .ProcDin(ProcDin), .ProcRun(ProcRun),
        .ProcDone(ProcDone), .PC(PC), .InstrCount(InstrCount),
        .Busy(Busy), .Halted(Halted), .Error(Error)
    );

    always #5 Clock = ~Clock;

    // Registered-output ROM.
    logic [8:0] rom [32];
    always @(posedge Clock or posedge Clear) begin
        if (Clear) RomQ <= '0;
        else       RomQ <= rom[RomAddr];
    end

    // Processor: Done arrives done_dly cycles after the Run cycle.
    int done_dly = 3;
    int pcnt;
    always @(posedge Clock or posedge Clear) begin
        if (Clear)         pcnt <= 0;
        else if (ProcRun)  pcnt <= done_dly;
        else if (pcnt > 0) pcnt <= pcnt - 1;
    end
    assign ProcDone = (pcnt == 1);

    // Observe Run pulses and every word presented on DIN (word, then imm).
    int         runs = 0;
    logic [8:0] trace [$];
    logic       want_imm = 1'b0;
    always @(negedge Clock) begin
        if (want_imm) trace.push_back(ProcDin);
        want_imm <= ProcRun && (ProcDin[8:6] == OP_MVI);
        if (ProcRun) begin
            runs <= runs + 1;
            trace.push_back(ProcDin);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        Clear = 1'b1; Start = 1'b0; Stop = 1'b0; Step = 1'b0;
        repeat (2) @(negedge Clock);
        Clear = 1'b0;
        @(negedge Clock);
    endtask

    task automatic rom_fill(input logic [8:0] w);
        for (int i = 0; i < 32; i++) rom[i] = w;
    endtask

    // Pulse Start for one cycle, then wait (bounded) until the sequencer settles.
    task automatic pulse_wait(input int budget);
        bit ok;
        ok = 1'b0;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            if (!Busy) begin ok = 1'b1; break; end
        end
        if (!ok) check("settle_bound", 0, 1);
    endtask

    typedef struct {
        logic [5:0][8:0] w;
        bit              step;
        int              dly;
        int              e_runs, e_pc, e_cnt;
        bit              e_halt, e_err;
    } vec_t;

    function automatic vec_t mk(input logic [8:0] a0, a1, a2, a3, a4, a5,
                                input bit st, input int d, input int r, input int p,
                                input int c, input bit h, input bit e);
        vec_t v;
        v.w[0] = a0; v.w[1] = a1; v.w[2] = a2; v.w[3] = a3; v.w[4] = a4; v.w[5] = a5;
        v.step = st; v.dly = d; v.e_runs = r; v.e_pc = p; v.e_cnt = c;
        v.e_halt = h; v.e_err = e;
        return v;
    endfunction

    vec_t vt [$];

    initial begin
        int base, tbase, total, h1, h2, found;
        int mpc, mcnt, n, d, idx;
        bit mh, me;
        logic [8:0] w;
        logic [8:0] ew [2];

        //  program                                          step dly runs pc cnt halt err
        vt.push_back(mk(W_MV,  W_ADD,  W_HALT, W_HALT, W_HALT, W_HALT, 0, 3,  2, 2, 2, 1, 0));
        vt.push_back(mk(W_MVI, 9'h005, W_HALT, W_HALT, W_HALT, W_HALT, 0, 1,  1, 2, 1, 1, 0));
        vt.push_back(mk(W_MVI, 9'h005, W_HALT, W_HALT, W_HALT, W_HALT, 0, 6,  1, 2, 1, 1, 0));
        vt.push_back(mk(W_MV,  W_ADD,  W_HALT, W_HALT, W_HALT, W_HALT, 0, 16, 1, 0, 0, 0, 1));
        vt.push_back(mk(W_ADD, W_HALT, W_HALT, W_HALT, W_HALT, W_HALT, 0, 15, 1, 1, 1, 1, 0));
        vt.push_back(mk(W_MV,  W_ADD,  W_HALT, W_HALT, W_HALT, W_HALT, 1, 2,  1, 1, 1, 0, 0));
        vt.push_back(mk(W_HALT, W_MV,  W_HALT, W_HALT, W_HALT, W_HALT, 0, 2,  0, 0, 0, 1, 0));
        vt.push_back(mk(W_MVI, 9'h005, W_MVI,  9'h007, W_ADD,  W_HALT, 0, 2,  3, 5, 3, 1, 0));
        vt.push_back(mk(W_MVI, 9'h005, W_HALT, W_HALT, W_HALT, W_HALT, 0, 16, 1, 0, 0, 0, 1));

        // Reset state.
        rom_fill(W_HALT);
        do_reset();
        check("rst_pc", PC, 0);
        check("rst_cnt", InstrCount, 0);
        check("rst_romaddr", RomAddr, 0);
        check("rst_din", ProcDin, 0);
        check("rst_run", ProcRun, 0);
        check("rst_flags", {Busy, Halted, Error}, 0);

        // Start together with Stop keeps the sequencer idle.
        Start = 1'b1; Stop = 1'b1;
        repeat (3) @(negedge Clock);
        check("start_stop_idle", Busy, 0);
        Start = 1'b0; Stop = 1'b0;

        // Table-driven programs.
        foreach (vt[k]) begin
            do_reset();
            rom_fill(W_HALT);
            for (int i = 0; i < 6; i++) rom[i] = vt[k].w[i];
            Step = vt[k].step;
            done_dly = vt[k].dly;
            base = runs;
            pulse_wait(80);
            check($sformatf("vec%0d_runs", k), runs - base, vt[k].e_runs);
            check($sformatf("vec%0d_pc", k), PC, vt[k].e_pc);
            check($sformatf("vec%0d_cnt", k), InstrCount, vt[k].e_cnt);
            check($sformatf("vec%0d_halt", k), Halted, vt[k].e_halt);
            check($sformatf("vec%0d_err", k), Error, vt[k].e_err);
        end

        // mvi: instruction word in ISSUE, immediate in the following cycle.
        do_reset();
        rom_fill(W_HALT);
        rom[0] = W_MVI; rom[1] = 9'h005;
        done_dly = 1;
        tbase = trace.size();
        pulse_wait(40);
        check("mvi_words", trace.size() - tbase, 2);
        if (trace.size() >= tbase + 2) begin
            check("mvi_issue_din", trace[tbase], W_MVI);
            check("mvi_imm_din", trace[tbase + 1], 9'h005);
        end
        check("mvi_pc", PC, 2);
        check("mvi_din_hold", ProcDin, 9'h005);

        // Single-step: one Run per Start, idle between.
        do_reset();
        rom_fill(W_HALT);
        rom[0] = W_MV; rom[1] = W_ADD; rom[2] = W_MV;
        Step = 1'b1;
        done_dly = 2;
        for (int s = 1; s <= 3; s++) begin
            base = runs;
            pulse_wait(40);
            check($sformatf("step%0d_runs", s), runs - base, 1);
            check($sformatf("step%0d_pc", s), PC, s);
            check($sformatf("step%0d_idle", s), {Busy, Halted, Error}, 0);
        end

        // Timeout leaves PC alone; Start from ERR restarts at 0.
        do_reset();
        rom_fill(W_HALT);
        rom[0] = W_MV; rom[1] = W_ADD;
        Step = 1'b1;
        done_dly = 2;
        pulse_wait(40);
        done_dly = 16;
        pulse_wait(60);
        check("tmo_err", Error, 1);
        check("tmo_pc", PC, 1);
        check("tmo_cnt", InstrCount, 1);
        done_dly = 2;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        check("tmo_restart_busy", {Busy, Error}, 2'b10);
        check("tmo_restart_pc", PC, 0);
        check("tmo_restart_cnt", InstrCount, 0);
        for (int i = 0; i < 40 && Busy; i++) @(negedge Clock);
        check("tmo_rerun_pc", PC, 1);

        // mvi at the top of the ROM wraps; Stop during EXEC ends after retire.
        do_reset();
        rom_fill(W_MV);
        rom[31] = W_MVI;
        done_dly = 3;
        base = runs;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        h1 = -1; h2 = -1; found = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge Clock);
            if (ProcRun && PC == 31) begin found = 1; break; end
            h2 = h1; h1 = int'(RomAddr);
        end
        check("wrap_found", found, 1);
        check("wrap_fetch_addr", h2, 31);
        check("wrap_imm_addr", h1, 0);
        @(negedge Clock);
        @(negedge Clock);
        Stop = 1'b1;
        for (int i = 0; i < 40 && Busy; i++) @(negedge Clock);
        check("wrap_pc", PC, 1);
        check("wrap_cnt", InstrCount, 32);
        check("wrap_runs", runs - base, 32);
        check("wrap_idle", {Busy, Halted, Error}, 0);
        Stop = 1'b0;

        // Asynchronous Clear in the middle of an EXEC.
        do_reset();
        rom_fill(W_HALT);
        rom[0] = W_MV; rom[1] = W_ADD;
        done_dly = 5;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clock);
            if (ProcRun && PC == 1) begin found = 1; break; end
        end
        check("clr_found", found, 1);
        check("clr_pre_cnt", InstrCount, 1);
        repeat (2) @(negedge Clock);
        #2 Clear = 1'b1;
        #1;
        check("clr_pc", PC, 0);
        check("clr_cnt", InstrCount, 0);
        check("clr_romaddr", RomAddr, 0);
        check("clr_din_run", {ProcDin, ProcRun}, 0);
        check("clr_flags", {Busy, Halted, Error}, 0);
        @(negedge Clock);
        Clear = 1'b0;

        // Retire counter saturates.
        do_reset();
        rom_fill(W_MV);
        done_dly = 1;
        base = runs;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        for (int i = 0; i < 4000 && (runs - base) < 300; i++) @(negedge Clock);
        Stop = 1'b1;
        for (int i = 0; i < 40 && Busy; i++) @(negedge Clock);
        total = runs - base;
        check("sat_ran300", total >= 300, 1);
        check("sat_cnt", InstrCount, 255);
        check("sat_pc", PC, total % 32);
        Stop = 1'b0;

        // Randomized single-step run against a program-level model.
        do_reset();
        for (int i = 0; i < 32; i++) rom[i] = 9'($urandom_range(0, 511));
        Step = 1'b1;
        mpc = 0; mcnt = 0; mh = 0; me = 0;
        for (int s = 0; s < 60; s++) begin
            d = ($urandom_range(0, 5) == 0) ? 16 : $urandom_range(1, TMO);
            done_dly = d;
            base = runs;
            tbase = trace.size();
            pulse_wait(80);
            if (mh || me) begin mpc = 0; mcnt = 0; mh = 0; me = 0; end
            w = rom[mpc];
            n = 0;
            if (w[8:6] == OP_HALT) begin
                mh = 1;
            end else begin
                ew[0] = w; n = 1;
                if (w[8:6] == OP_MVI) begin ew[1] = rom[(mpc + 1) % 32]; n = 2; end
                if (d > TMO) me = 1;
                else begin
                    mpc = (mpc + ((w[8:6] == OP_MVI) ? 2 : 1)) % 32;
                    mcnt = (mcnt < 255) ? mcnt + 1 : 255;
                end
            end
            check($sformatf("rnd%0d_pc", s), PC, mpc);
            check($sformatf("rnd%0d_cnt", s), InstrCount, mcnt);
            check($sformatf("rnd%0d_flags", s), {Halted, Error}, {mh, me});
            check($sformatf("rnd%0d_runs", s), runs - base, (n > 0) ? 1 : 0);
            check($sformatf("rnd%0d_nwords", s), trace.size() - tbase, n);
            for (int j = 0; j < n; j++) begin
                idx = tbase + j;
                if (idx < trace.size()) check($sformatf("rnd%0d_word%0d", s, j), trace[idx], ew[j]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
